// File: rtl/mxu_stream_sequencer.sv
// mxu_stream_sequencer: collects DIM x DIM A and B operands from an element
// stream, fires a single start pulse at temporal_mxu, captures the result on a
// fresh valid edge and streams the result elements back out in row-major order.
module mxu_stream_sequencer #(
    parameter int BIT_WIDTH = 4,
    parameter int DIM       = 2,
    parameter int TIMEOUT   = 1024
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [BIT_WIDTH-1:0]                      in_data,
    output logic                                      mxu_start,
    output logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]    mxu_A,
    output logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]    mxu_B,
    input  logic                                      mxu_out_valid,
    input  logic [DIM-1:0][DIM-1:0][2*BIT_WIDTH-1:0]  mxu_out,
    output logic                                      res_valid,
    input  logic                                      res_ready,
    output logic [2*BIT_WIDTH-1:0]                    res_data,
    output logic                                      res_last,
    output logic                                      busy,
    output logic                                      err
);

    localparam int NELEM = DIM * DIM;
    localparam int IW    = (NELEM > 1) ? $clog2(NELEM) : 1;
    localparam int RW    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IW-1:0] IDX_LAST  = IW'(NELEM - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        DRAIN
    } state_t;

    state_t                                    r_state;
    state_t                                    w_nextState;
    logic [IW-1:0]                             r_idx;
    logic [CW-1:0]                             r_waitCnt;
    logic                                      r_prevValid;
    logic                                      r_err;
    logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]    r_mxuA;
    logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]    r_mxuB;
    logic [DIM-1:0][DIM-1:0][2*BIT_WIDTH-1:0]  r_resBuf;

    logic [RW-1:0] w_row;
    logic [RW-1:0] w_col;
    logic          w_idxLast;
    logic          w_inFire;
    logic          w_resFire;
    logic          w_rise;
    logic          w_start;
    logic          w_resValid;
    logic          w_capture;
    logic          w_timeout;

    // The same element index walks the operand matrices while loading and the
    // result buffer while draining, so one row/column decode serves both.
    assign w_row     = RW'(int'(r_idx) / DIM);
    assign w_col     = RW'(int'(r_idx) % DIM);
    assign w_idxLast = (r_idx == IDX_LAST);

    assign in_ready  = reset_n && ((r_state == LOAD_A) || (r_state == LOAD_B));
    assign w_inFire  = in_valid && in_ready;
    assign w_resFire = w_resValid && res_ready;

    // Only a low-to-high transition counts as a new result, so a valid level
    // left over from an earlier operation cannot be mistaken for this one.
    assign w_rise    = mxu_out_valid && !r_prevValid;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and the per-state control strobes.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_resValid  = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            LOAD_A: begin
                if (w_inFire && w_idxLast) begin
                    w_nextState = LOAD_B;
                end
            end
            LOAD_B: begin
                if (w_inFire && w_idxLast) begin
                    w_nextState = START;
                end
            end
            START: begin
                w_start     = 1'b1;
                w_nextState = WAIT;
            end
            WAIT: begin
                if (w_rise) begin
                    w_capture   = 1'b1;
                    w_nextState = DRAIN;
                end else if ((TIMEOUT != 0) && (r_waitCnt == WAIT_LAST)) begin
                    w_timeout   = 1'b1;
                    w_nextState = LOAD_A;
                end
            end
            DRAIN: begin
                w_resValid = 1'b1;
                if (res_ready && w_idxLast) begin
                    w_nextState = LOAD_A;
                end
            end
            default: begin
                w_nextState = LOAD_A;
            end
        endcase
    end

    // Element index: advances on every operand or result handshake and wraps
    // to zero at the end of a matrix or when a wait ends either way.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idx <= '0;
        end else if (w_inFire || w_resFire) begin
            r_idx <= w_idxLast ? '0 : (r_idx + 1'b1);
        end else if (w_capture || w_timeout) begin
            r_idx <= '0;
        end
    end

    // Operand matrices: written element by element and otherwise held, so the
    // MXU sees stable operands through the start pulse and the whole wait.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mxuA <= '0;
            r_mxuB <= '0;
        end else if (w_inFire) begin
            if (r_state == LOAD_A) begin
                r_mxuA[w_row][w_col] <= in_data;
            end else begin
                r_mxuB[w_row][w_col] <= in_data;
            end
        end
    end

    // Result buffer: snapshot of the MXU output taken on the capture edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_resBuf <= '0;
        end else if (w_capture) begin
            r_resBuf <= mxu_out;
        end
    end

    // Wait counter: zeroed by the start pulse, counts wait cycles without a result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_waitCnt <= '0;
        end else if (w_start) begin
            r_waitCnt <= '0;
        end else if ((r_state == WAIT) && !w_capture && !w_timeout) begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

    // Previous MXU valid level, tracked in every state for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prevValid <= 1'b0;
        end else begin
            r_prevValid <= mxu_out_valid;
        end
    end

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign mxu_A     = r_mxuA;
    assign mxu_B     = r_mxuB;
    assign mxu_start = w_start;
    assign res_valid = w_resValid;
    assign res_data  = r_resBuf[w_row][w_col];
    assign res_last  = w_resValid && w_idxLast;
    assign busy      = !((r_state == LOAD_A) && (r_idx == '0));
    assign err       = r_err;

endmodule

// File: tb/tb_mxu_stream_sequencer.sv
// tb_mxu_stream_sequencer: table-driven and randomized checks of the stream
// sequencer against a behavioural matrix-multiply reference and an MXU stub.
module tb_mxu_stream_sequencer;

    typedef struct packed {
        logic [0:3][3:0] a;
        logic [0:3][3:0] b;
        logic [1:0]      bp;
        logic            gap;
        logic [0:3][7:0] c;
    } vec_t;

    localparam logic [1:0][1:0][7:0] STUB_JUNK = 32'hA5C3_5A3C;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [3:0]             in_data;
    logic                   mxu_start;
    logic [1:0][1:0][3:0]   mxu_A;
    logic [1:0][1:0][3:0]   mxu_B;
    logic                   mxu_out_valid = 1'b0;
    logic [1:0][1:0][7:0]   mxu_out = '0;
    logic                   res_valid;
    logic                   res_ready;
    logic [7:0]             res_data;
    logic                   res_last;
    logic                   busy;
    logic                   err;

    int total = 0;
    int bad = 0;
    int startTotal = 0;
    int startBase = 0;
    int stubMode = 0;
    int stubLat = 3;
    int stubCnt = 0;
    logic stubArmed = 1'b0;
    logic [1:0][1:0][7:0] stubC = '0;

    mxu_stream_sequencer #(
        .BIT_WIDTH (4),
        .DIM       (2),
        .TIMEOUT   (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .mxu_start     (mxu_start),
        .mxu_A         (mxu_A),
        .mxu_B         (mxu_B),
        .mxu_out_valid (mxu_out_valid),
        .mxu_out       (mxu_out),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_last      (res_last),
        .busy          (busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    // Reference product: C[i][j] = sum_k A[i][k]*B[k][j], kept modulo 256.
    function automatic logic [0:3][7:0] refMatmul(input logic [0:3][3:0] a, input logic [0:3][3:0] b);
        logic [0:3][7:0] c;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 2; k++) begin
                    s = s + int'(a[i*2+k]) * int'(b[k*2+j]);
                end
                c[i*2+j] = 8'(s % 256);
            end
        end
        return c;
    endfunction

    // Stub MXU arithmetic on the matrices as the sequencer presents them.
    function automatic logic [1:0][1:0][7:0] stubMatmul(input logic [1:0][1:0][3:0] a, input logic [1:0][1:0][3:0] b);
        logic [1:0][1:0][7:0] c;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                int s;
                s = a[i][0] * b[0][j] + a[i][1] * b[1][j];
                c[i][j] = 8'(s % 256);
            end
        end
        return c;
    endfunction

    // MXU stub: mode 0 pulses valid stubLat cycles after start, mode 1 holds a
    // stale valid level and re-raises it 5 cycles after start, mode 2 never answers.
    always @(negedge clk) begin
        if (mxu_start === 1'b1) begin
            stubCnt   = 0;
            stubArmed = 1'b1;
            stubC     = stubMatmul(mxu_A, mxu_B);
        end else if (stubArmed && stubCnt < 1000) begin
            stubCnt++;
        end
        case (stubMode)
            0: begin
                mxu_out_valid = stubArmed && (stubCnt == stubLat);
                mxu_out       = (stubArmed && (stubCnt == stubLat)) ? stubC : STUB_JUNK;
            end
            1: begin
                mxu_out_valid = !(stubArmed && (stubCnt == 4));
                mxu_out       = (stubArmed && (stubCnt >= 5)) ? stubC : STUB_JUNK;
            end
            default: begin
                mxu_out_valid = 1'b0;
                mxu_out       = STUB_JUNK;
            end
        endcase
    end

    // Running count of start pulses seen by the bench.
    always @(negedge clk) begin
        if (mxu_start === 1'b1) begin
            startTotal++;
        end
    end

    // Hard stop in case something never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Streams the first 'count' operand beats (A then B); called and returns on a negedge.
    task automatic applyStimulus(input logic [0:3][3:0] a, input logic [0:3][3:0] b, input logic gapped, input int count);
        int n;
        int guard;
        logic fired;
        logic [1:0][1:0][3:0] expA;
        logic [1:0][1:0][3:0] expB;
        n = 0;
        guard = 0;
        startBase = startTotal;
        while (n < count && guard < 200) begin
            in_valid = gapped ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (n < 4) begin
                in_data = a[n];
            end else begin
                in_data = b[n-4];
            end
            checkOutput("busyLoad", busy, n != 0);
            fired = in_valid && in_ready;
            @(negedge clk);
            if (fired) begin
                n++;
            end
            guard++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        checkOutput("loadBeats", n, count);
        if (count == 8) begin
            checkOutput("startAfterLoad", mxu_start, 1'b1);
            for (int e = 0; e < 4; e++) begin
                expA[e/2][e%2] = a[e];
                expB[e/2][e%2] = b[e];
            end
            checkOutput("mxuA", mxu_A, expA);
            checkOutput("mxuB", mxu_B, expB);
        end
    endtask

    // Waits for the result and drains it under the chosen backpressure mode.
    task automatic drainResults(input logic [0:3][7:0] expC, input int bpMode, input int expWait);
        int waited;
        int nres;
        int k;
        waited = 0;
        while (res_valid !== 1'b1 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("resLatency", waited, expWait);
        if (res_valid === 1'b1) begin
            nres = 0;
            k = 0;
            while (nres < 4 && k < 64) begin
                case (bpMode)
                    0: res_ready = 1'b1;
                    1: res_ready = (k % 3 == 0);
                    default: res_ready = ($urandom_range(0, 1) == 1);
                endcase
                checkOutput("resValid", res_valid, 1'b1);
                checkOutput("resData", res_data, expC[nres]);
                checkOutput("resLast", res_last, nres == 3);
                if (res_ready) begin
                    nres++;
                end
                k++;
                @(negedge clk);
            end
            res_ready = 1'b0;
            checkOutput("resCount", nres, 4);
            checkOutput("inReadyBack", in_ready, 1'b1);
            checkOutput("resValidDone", res_valid, 1'b0);
            checkOutput("startPulses", startTotal - startBase, 1);
        end
    endtask

    initial begin
        vec_t vecs [6];
        logic [0:3][3:0] ra;
        logic [0:3][3:0] rb;
        logic sawValid;
        logic sawReady;

        vecs[0] = '{a: {4'd1, 4'd2, 4'd3, 4'd0}, b: {4'd2, 4'd2, 4'd0, 4'd2}, bp: 2'd0, gap: 1'b0, c: {8'd2, 8'd6, 8'd6, 8'd6}};
        vecs[1] = '{a: {4'd1, 4'd0, 4'd0, 4'd1}, b: {4'd5, 4'd7, 4'd9, 4'd11}, bp: 2'd0, gap: 1'b0, c: {8'd5, 8'd7, 8'd9, 8'd11}};
        vecs[2] = '{a: {4'd15, 4'd15, 4'd0, 4'd1}, b: {4'd15, 4'd2, 4'd2, 4'd3}, bp: 2'd0, gap: 1'b0, c: {8'd255, 8'd75, 8'd2, 8'd3}};
        vecs[3] = '{a: {4'd2, 4'd3, 4'd4, 4'd5}, b: {4'd6, 4'd7, 4'd8, 4'd9}, bp: 2'd0, gap: 1'b0, c: {8'd36, 8'd41, 8'd64, 8'd73}};
        vecs[4] = '{a: {4'd1, 4'd2, 4'd3, 4'd0}, b: {4'd2, 4'd2, 4'd0, 4'd2}, bp: 2'd1, gap: 1'b0, c: {8'd2, 8'd6, 8'd6, 8'd6}};
        vecs[5] = '{a: {4'd1, 4'd2, 4'd3, 4'd0}, b: {4'd2, 4'd2, 4'd0, 4'd2}, bp: 2'd0, gap: 1'b1, c: {8'd2, 8'd6, 8'd6, 8'd6}};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstInReady", in_ready, 1'b0);
        checkOutput("rstMxuA", mxu_A, '0);
        checkOutput("rstMxuB", mxu_B, '0);
        checkOutput("rstStart", mxu_start, 1'b0);
        checkOutput("rstResValid", res_valid, 1'b0);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstErr", err, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idleInReady", in_ready, 1'b1);

        // Table: plain ops, backpressured op and gapped-input op.
        stubMode = 0;
        stubLat  = 3;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].gap, 8);
            drainResults(vecs[i].c, int'(vecs[i].bp), 4);
        end

        // Stale valid level: capture only on the fresh edge 5 cycles after start.
        stubMode = 1;
        applyStimulus(vecs[3].a, vecs[3].b, 1'b0, 8);
        drainResults(vecs[3].c, 0, 6);
        stubMode = 0;

        // Randomized operands, input gaps, MXU latency and result backpressure.
        for (int t = 0; t < 6; t++) begin
            for (int e = 0; e < 4; e++) begin
                ra[e] = 4'($urandom_range(0, 15));
                rb[e] = 4'($urandom_range(0, 15));
            end
            stubLat = int'($urandom_range(1, 10));
            applyStimulus(ra, rb, 1'b1, 8);
            drainResults(refMatmul(ra, rb), 2, stubLat + 1);
        end

        // Timeout: no answer for 16 wait cycles aborts back to loading.
        stubMode = 2;
        applyStimulus(vecs[1].a, vecs[1].b, 1'b0, 8);
        sawValid = 1'b0;
        sawReady = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            sawValid = sawValid | res_valid;
            sawReady = sawReady | in_ready;
            if (i == 16) begin
                checkOutput("errBeforeTimeout", err, 1'b0);
            end
        end
        checkOutput("noResInWait", sawValid, 1'b0);
        checkOutput("noReadyInWait", sawReady, 1'b0);
        @(negedge clk);
        checkOutput("errSet", err, 1'b1);
        checkOutput("inReadyAfterTimeout", in_ready, 1'b1);
        checkOutput("busyAfterTimeout", busy, 1'b0);
        checkOutput("noResAfterTimeout", res_valid, 1'b0);

        // The flag stays up through a following good operation.
        stubMode = 0;
        stubLat  = 2;
        applyStimulus(vecs[1].a, vecs[1].b, 1'b0, 8);
        drainResults(vecs[1].c, 0, 3);
        checkOutput("errSticky", err, 1'b1);

        // One-cycle reset in LOAD_B after two B beats discards the partial load.
        stubLat = 3;
        applyStimulus(vecs[3].a, vecs[3].b, 1'b0, 6);
        checkOutput("busyMidLoad", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        checkOutput("inReadyInReset", in_ready, 1'b0);
        @(negedge clk);
        checkOutput("midRstMxuA", mxu_A, '0);
        checkOutput("midRstMxuB", mxu_B, '0);
        checkOutput("midRstStart", mxu_start, 1'b0);
        checkOutput("midRstResValid", res_valid, 1'b0);
        checkOutput("midRstResLast", res_last, 1'b0);
        checkOutput("midRstBusy", busy, 1'b0);
        checkOutput("midRstErr", err, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("inReadyAfterRst", in_ready, 1'b1);
        applyStimulus(vecs[3].a, vecs[3].b, 1'b0, 8);
        drainResults(vecs[3].c, 1, 4);
        checkOutput("errAfterRstOp", err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mxu_stream_sequencer.md
Name: mxu_stream_sequencer

Overview:
- Front-end and back-end sequencer for temporal_mxu.
- Accepts operand elements one per beat on a valid/ready stream and assembles the DIM x DIM A and B matrices. Then pulses the MXU start, waits for its result, and returns the DIM x DIM result elements one per beat on a valid/ready stream.
- Sits directly between the host/DMA element stream and temporal_mxu. Drives mxu_A, mxu_B and mxu_start; consumes mxu_out and mxu_out_valid.

Parameters:
- BIT_WIDTH, 4, operand element width.
- DIM, 2, matrix dimension; A, B and C are all DIM x DIM.
- TIMEOUT, 1024, maximum WAIT cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand element valid.
- in_ready  out  1  sequencer can accept an operand element.
- in_data  in  BIT_WIDTH  operand element.
- mxu_start  out  1  one-cycle start pulse to the MXU.
- mxu_A  out  [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]  A matrix to the MXU.
- mxu_B  out  [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]  B matrix to the MXU.
- mxu_out_valid  in  1  MXU result valid.
- mxu_out  in  [DIM-1:0][DIM-1:0][2*BIT_WIDTH-1:0]  MXU result.
- res_valid  out  1  result element valid.
- res_ready  in  1  downstream accepts a result element.
- res_data  out  2*BIT_WIDTH  result element.
- res_last  out  1  high with the final result element of a matrix.
- busy  out  1  high in any state other than LOAD_A with idx==0.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous, active-low.
- Reset values (while reset_n==0 at a posedge and thereafter until the first transition):
  - state=LOAD_A, idx=0.
  - mxu_A=0, mxu_B=0, result buffer=0.
  - mxu_start=0, res_valid=0, res_last=0, err=0, wait counter=0, prev_out_valid=0.
  - in_ready is forced 0 while reset_n==0.
- States: LOAD_A, LOAD_B, START, WAIT, DRAIN. idx counts 0..DIM*DIM-1, width $clog2(DIM*DIM) (minimum 1).
- LOAD_A:
  - in_ready=1.
  - On in_valid&in_ready, write in_data to mxu_A[idx/DIM][idx%DIM] (row-major) and increment idx.
  - On the handshake at idx==DIM*DIM-1: idx<=0, go to LOAD_B.
- LOAD_B: same as LOAD_A but writes mxu_B. On the last element, go to START.
- START:
  - in_ready=0, mxu_start=1 for exactly this one cycle.
  - Clear the wait counter; go to WAIT next cycle.
- WAIT:
  - in_ready=0.
  - prev_out_valid is registered every cycle, in all states.
  - Capture the result only on a rising edge seen in WAIT: mxu_out_valid==1 && prev_out_valid==0. A level left high from a prior op is ignored.
  - On capture, latch mxu_out into the result buffer, idx<=0, go to DRAIN.
  - Otherwise increment the wait counter. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without capture: err<=1, idx<=0, go to LOAD_A. No result is drained.
- DRAIN:
  - res_valid=1, res_data=buffer[idx/DIM][idx%DIM] (row-major), res_last=(idx==DIM*DIM-1).
  - On res_valid&res_ready, increment idx. The last handshake sets idx<=0 and goes to LOAD_A.
  - res_data and res_last hold stable while res_valid&&!res_ready.
- mxu_A and mxu_B hold their values from the last load write until overwritten by the next LOAD phase, so they are stable throughout START and WAIT.
- Latency:
  - Last B handshake at cycle T: mxu_start high in T+1; WAIT starts at T+2.
  - Rising edge of mxu_out_valid captured at cycle R: res_valid high at R+1.
  - Back-to-back: in_ready returns 1 the cycle after the final result handshake.
- Width rule: result elements pass through unmodified at 2*BIT_WIDTH bits; there is no saturation.
- Mid-operation reset: a synchronous reset in any state returns everything to reset values next cycle. Partially loaded operands and undrained results are discarded.
- mxu_out_valid outside WAIT: ignored (only tracked by prev_out_valid).

Test Plan:
- Basic op with an MXU stub computing A*B, A=[[1,2],[3,0]], B=[[2,2],[0,2]]: 8 operand beats, then exactly one mxu_start pulse; results 2,6,6,6 in order, res_last only on the 4th.
- Backpressure: same op with res_ready toggling 1,0,0,1,...: each element held stable while stalled; exactly 4 handshakes; in_ready returns 1 the cycle after the 4th.
- Gapped input with in_valid randomly low: mxu_A=[[1,2],[3,0]] and mxu_B=[[2,2],[0,2]] exact; mxu_start the cycle after the 8th handshake.
- Stale level: stub holds mxu_out_valid=1 from cycle 0 and asserts a new rising edge 5 cycles after start: capture only on the new edge, with its data.
- Timeout (TIMEOUT=16, stub never asserts valid): err=1 after 16 WAIT cycles, no res_valid, in_ready=1 next cycle; err stays high through a following good op.
- reset_n=0 for one cycle during LOAD_B after 2 B elements: all outputs 0 next cycle, state LOAD_A; a fresh 8-element op then completes correctly.
